// File: rtl/udmabuf_tb_main.sv
// Wishbone peripheral top for the udmabuf sample: two 128-bit DMA test engines over a shared
// 256-word memory model, an LED register, and an interval timer built only with UDMABUF_TB_MAIN_TIMER_EN.
module udmabuf_tb_main #(
    parameter int                      WB_ADR_WIDTH = 37,
    parameter int                      WB_DAT_WIDTH = 64,
    parameter int                      WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int                      MEM_LATENCY  = 4,
    parameter logic [WB_DAT_WIDTH-1:0] DMA_CORE_ID  = 64'h0000_0000_527A_0108
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_peri_adr_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_peri_dat_o,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_peri_dat_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_peri_sel_i,
    input  logic                    s_wb_peri_we_i,
    input  logic                    s_wb_peri_stb_i,
    output logic                    s_wb_peri_ack_o
);

    localparam int MW    = 2 * WB_DAT_WIDTH;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [7:0] RGN_DMA0 = 8'h00;
    localparam logic [7:0] RGN_DMA1 = 8'h01;
    localparam logic [7:0] RGN_LED  = 8'h10;
    localparam logic [7:0] RGN_TIM  = 8'h20;

    typedef enum logic [3:0] {
        DMA_STATUS  = 4'd0,
        DMA_WSTART  = 4'd1,
        DMA_RSTART  = 4'd2,
        DMA_ADDR    = 4'd3,
        DMA_WDATA0  = 4'd4,
        DMA_WDATA1  = 4'd5,
        DMA_RDATA0  = 4'd6,
        DMA_RDATA1  = 4'd7,
        DMA_CORE_ID_REG = 4'd8
    } dma_reg_e;

    function automatic logic [WB_DAT_WIDTH-1:0] byte_merge(
        input logic [WB_DAT_WIDTH-1:0] cur,
        input logic [WB_DAT_WIDTH-1:0] wdat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        byte_merge = cur;
        for (int b = 0; b < WB_SEL_WIDTH; b++)
            if (sel[b]) byte_merge[b*8 +: 8] = wdat[b*8 +: 8];
    endfunction

    logic [7:0] region;
    logic [3:0] reg_idx;
    logic       wr_en;
    logic [1:0] dma_wr;
    logic       unused_adr;

    assign region          = s_wb_peri_adr_i[15:8];
    assign reg_idx         = s_wb_peri_adr_i[3:0];
    assign wr_en           = s_wb_peri_stb_i & s_wb_peri_we_i;
    assign dma_wr[0]       = wr_en && (region == RGN_DMA0);
    assign dma_wr[1]       = wr_en && (region == RGN_DMA1);
    assign s_wb_peri_ack_o = s_wb_peri_stb_i;
    assign unused_adr      = ^{s_wb_peri_adr_i[WB_ADR_WIDTH-1:16], s_wb_peri_adr_i[7:4]};

    // ---------------- DMA engines ----------------
    logic                    busy    [2];
    logic                    is_read [2];
    logic [CNT_W-1:0]        cnt     [2];
    logic [WB_DAT_WIDTH-1:0] addr    [2];
    logic [WB_DAT_WIDTH-1:0] wdata0  [2];
    logic [WB_DAT_WIDTH-1:0] wdata1  [2];
    logic [WB_DAT_WIDTH-1:0] rdata0  [2];
    logic [WB_DAT_WIDTH-1:0] rdata1  [2];
    logic [MW-1:0]           mem_rd  [2];
    logic [WB_DAT_WIDTH-1:0] dma_rdata [2];
    logic [1:0]              done;
    logic [1:0]              grant;

    logic [MW-1:0] mem [256];
    logic          mem_we;
    logic [7:0]    mem_widx;
    logic [MW-1:0] mem_wdata;

    // DMA0 wins a same-cycle completion; DMA1 stays busy with cnt=0 and completes next edge.
    assign done[0]  = busy[0] && (cnt[0] == '0);
    assign done[1]  = busy[1] && (cnt[1] == '0);
    assign grant[0] = done[0];
    assign grant[1] = done[1] && !done[0];

    // NOTE: state is updated with non-blocking assignments so both engines see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                busy[i]    <= 1'b0;
                is_read[i] <= 1'b0;
                cnt[i]     <= '0;
                addr[i]    <= '0;
                wdata0[i]  <= '0;
                wdata1[i]  <= '0;
                rdata0[i]  <= '0;
                rdata1[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) begin
                    if (grant[i]) begin
                        busy[i] <= 1'b0;
                        if (is_read[i]) begin
                            rdata0[i] <= mem_rd[i][WB_DAT_WIDTH-1:0];
                            rdata1[i] <= mem_rd[i][MW-1:WB_DAT_WIDTH];
                        end
                    end else if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                    end
                end else if (dma_wr[i] && s_wb_peri_dat_i[0] &&
                             (reg_idx == DMA_WSTART || reg_idx == DMA_RSTART)) begin
                    busy[i]    <= 1'b1;
                    is_read[i] <= (reg_idx == DMA_RSTART);
                    cnt[i]     <= CNT_W'(MEM_LATENCY - 1);
                end
                if (dma_wr[i]) begin
                    case (reg_idx)
                        DMA_ADDR:   addr[i]   <= byte_merge(addr[i],   s_wb_peri_dat_i, s_wb_peri_sel_i);
                        DMA_WDATA0: wdata0[i] <= byte_merge(wdata0[i], s_wb_peri_dat_i, s_wb_peri_sel_i);
                        DMA_WDATA1: wdata1[i] <= byte_merge(wdata1[i], s_wb_peri_dat_i, s_wb_peri_sel_i);
                        default: ;
                    endcase
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = addr[0][11:4];
        mem_wdata = {wdata1[0], wdata0[0]};
        if (grant[0] && !is_read[0]) begin
            mem_we = 1'b1;
        end else if (grant[1] && !is_read[1]) begin
            mem_we    = 1'b1;
            mem_widx  = addr[1][11:4];
            mem_wdata = {wdata1[1], wdata0[1]};
        end
    end

    // NOTE: the memory model has no reset; its contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_rd[i]    = mem[addr[i][11:4]];
            dma_rdata[i] = '0;
            case (reg_idx)
                DMA_STATUS:      dma_rdata[i] = {{(WB_DAT_WIDTH-1){1'b0}}, busy[i]};
                DMA_ADDR:        dma_rdata[i] = addr[i];
                DMA_WDATA0:      dma_rdata[i] = wdata0[i];
                DMA_WDATA1:      dma_rdata[i] = wdata1[i];
                DMA_RDATA0:      dma_rdata[i] = rdata0[i];
                DMA_RDATA1:      dma_rdata[i] = rdata1[i];
                DMA_CORE_ID_REG: dma_rdata[i] = DMA_CORE_ID;
                default: ;
            endcase
        end
    end

    // ---------------- LED ----------------
    logic [7:0] led;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            led <= 8'h00;
        else if (wr_en && region == RGN_LED && reg_idx == 4'd0 && s_wb_peri_sel_i[0])
            led <= s_wb_peri_dat_i[7:0];
    end

    // ---------------- Timer ----------------
    logic [WB_DAT_WIDTH-1:0] tim_rdata;

`ifdef UDMABUF_TB_MAIN_TIMER_EN
    localparam logic [3:0] TIM_CONTROL = 4'd0;
    localparam logic [3:0] TIM_COMPARE = 4'd1;
    localparam logic [3:0] TIM_COUNTER = 4'd3;

    logic                    tim_en;
    logic [WB_DAT_WIDTH-1:0] tim_cmp;
    logic [WB_DAT_WIDTH-1:0] tim_cnt;
    logic                    tim_wr;

    assign tim_wr = wr_en && (region == RGN_TIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tim_en  <= 1'b0;
            tim_cmp <= '0;
            tim_cnt <= '0;
        end else begin
            if (tim_en)
                tim_cnt <= (tim_cnt == tim_cmp) ? '0 : tim_cnt + WB_DAT_WIDTH'(1);
            if (tim_wr) begin
                case (reg_idx)
                    TIM_CONTROL: if (s_wb_peri_sel_i[0]) tim_en <= s_wb_peri_dat_i[0];
                    TIM_COMPARE: tim_cmp <= byte_merge(tim_cmp, s_wb_peri_dat_i, s_wb_peri_sel_i);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tim_rdata = '0;
        case (reg_idx)
            TIM_CONTROL: tim_rdata = {{(WB_DAT_WIDTH-1){1'b0}}, tim_en};
            TIM_COMPARE: tim_rdata = tim_cmp;
            TIM_COUNTER: tim_rdata = tim_cnt;
            default: ;
        endcase
    end
`else
    assign tim_rdata = '0;
`endif

    // ---------------- Read mux ----------------
    always_comb begin
        s_wb_peri_dat_o = '0;
        if (s_wb_peri_stb_i) begin
            case (region)
                RGN_DMA0: s_wb_peri_dat_o = dma_rdata[0];
                RGN_DMA1: s_wb_peri_dat_o = dma_rdata[1];
                RGN_LED:  if (reg_idx == 4'd0) s_wb_peri_dat_o = WB_DAT_WIDTH'(led);
                RGN_TIM:  s_wb_peri_dat_o = tim_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udmabuf_tb_main.sv
// Self-checking bench for udmabuf_tb_main: directed scenarios plus randomized DMA/LED traffic
// checked against a transaction-level model of the memory and registers.
module tb_udmabuf_tb_main;

    localparam int          LAT     = 4;
    localparam logic [63:0] CORE_ID = 64'h0000_0000_527A_0108;
    localparam logic [36:0] LED_A   = 37'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [36:0] adr;
    logic [63:0] dat_o;
    logic [63:0] dat_i;
    logic [7:0]  sel;
    logic        we;
    logic        stb;
    logic        ack;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    logic [63:0]  m_addr [2];
    logic [63:0]  m_wd0  [2];
    logic [63:0]  m_wd1  [2];
    logic [63:0]  m_rd0  [2];
    logic [63:0]  m_rd1  [2];
    logic [127:0] m_mem  [int];
    logic [7:0]   m_led;
    logic [63:0]  t_cnt, t_cmp;
    logic         t_en;

    udmabuf_tb_main #(.MEM_LATENCY(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_wb_peri_adr_i (adr),
        .s_wb_peri_dat_o (dat_o),
        .s_wb_peri_dat_i (dat_i),
        .s_wb_peri_sel_i (sel),
        .s_wb_peri_we_i  (we),
        .s_wb_peri_stb_i (stb),
        .s_wb_peri_ack_o (ack)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] dma_a(input int eng, input int r);
        return 37'(eng * 256 + r);
    endfunction

    function automatic logic [36:0] tim_a(input int r);
        return 37'(32'h2000 + r);
    endfunction

    function automatic logic [63:0] bmerge(input logic [63:0] cur, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r = cur;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance the timer model by one clock edge, then apply a CONTROL write seen at that edge.
    task automatic tim_edge(input logic wr_ctl, input logic val);
        if (t_en) t_cnt = (t_cnt == t_cmp) ? 64'd0 : t_cnt + 64'd1;
        if (wr_ctl) t_en = val;
    endtask

    task automatic wb_write(input logic [36:0] a, input logic [63:0] d, input logic [7:0] s);
        adr = a; dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [36:0] a, output logic [63:0] d);
        adr = a; we = 1'b0; stb = 1'b1;
        #1;
        d = dat_o;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL ack adr=%h: got %b expected 1", a, ack); end
        stb = 1'b0;
    endtask

    task automatic wait_idle(input int e);
        logic [63:0] d;
        int n = 0;
        wb_read(dma_a(e, 0), d);
        while (d[0] === 1'b1 && n < 64) begin
            tick(1);
            n++;
            wb_read(dma_a(e, 0), d);
        end
        checks++;
        if (d[0] !== 1'b0) begin errors++; $display("FAIL wait_idle dma%0d: busy=%b after %0d cycles expected 0", e, d[0], n); end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wd0[i] = '0; m_wd1[i] = '0; m_rd0[i] = '0; m_rd1[i] = '0;
        end
        m_led = '0; t_cnt = '0; t_cmp = '0; t_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
        reset = 1'b0;
        model_reset();
        #12;
        checks++;
        if (ack !== 1'b0 || dat_o !== 64'd0) begin
            errors++; $display("FAIL idle_bus: got ack=%b dat=%h expected ack=0 dat=0", ack, dat_o);
        end
        reset = 1'b1;
        tick(1);
        for (int e = 0; e < 2; e++) begin
            for (int r = 0; r < 8; r++) begin
                wb_read(dma_a(e, r), d);
                checks++;
                if (d !== 64'd0) begin errors++; $display("FAIL reset dma%0d reg%0d: got %h expected 0", e, r, d); end
            end
        end
        wb_read(LED_A, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL reset led: got %h expected 0", d); end
    endtask

    task automatic test_core_id();
        logic [63:0] d;
        for (int e = 0; e < 2; e++) begin
            wb_read(dma_a(e, 8), d);
            checks++;
            if (d !== CORE_ID) begin errors++; $display("FAIL core_id dma%0d: got %h expected %h", e, d, CORE_ID); end
        end
        wb_read(37'h0508, d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL unmapped: got %h expected 0", d); end
        wb_read(dma_a(0, 15), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL unlisted_idx: got %h expected 0", d); end
    endtask

    task automatic test_dma0_write();
        logic [63:0] d;
        m_addr[0] = 64'h0; m_wd0[0] = 64'hfedcba98_76543210; m_wd1[0] = 64'h01234567_89abcdef;
        wb_write(dma_a(0, 3), m_addr[0], 8'hFF);
        wb_write(dma_a(0, 4), m_wd0[0], 8'hFF);
        wb_write(dma_a(0, 5), m_wd1[0], 8'hFF);
        wb_write(dma_a(0, 1), 64'd1, 8'hFF);
        for (int k = 0; k < LAT; k++) begin
            wb_read(dma_a(0, 0), d);
            checks++;
            if (d !== 64'd1) begin errors++; $display("FAIL dma0_busy cycle%0d: got %h expected 1", k + 1, d); end
            tick(1);
        end
        wb_read(dma_a(0, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL dma0_done: got %h expected 0", d); end
        m_mem[0] = {m_wd1[0], m_wd0[0]};
    endtask

    task automatic test_dma1_and_reads();
        logic [63:0] d;
        m_addr[1] = 64'h100; m_wd0[1] = 64'h55aa55aa_55aa55aa; m_wd1[1] = 64'haa55aa55_aa55aa55;
        wb_write(dma_a(1, 3), m_addr[1], 8'hFF);
        wb_write(dma_a(1, 4), m_wd0[1], 8'hFF);
        wb_write(dma_a(1, 5), m_wd1[1], 8'hFF);
        wb_write(dma_a(1, 1), 64'd1, 8'hFF);
        wait_idle(1);
        m_mem[16] = {m_wd1[1], m_wd0[1]};
        wb_write(dma_a(0, 2), 64'd1, 8'hFF);
        wb_write(dma_a(1, 2), 64'd1, 8'hFF);
        wait_idle(0);
        wait_idle(1);
        for (int e = 0; e < 2; e++) begin
            {m_rd1[e], m_rd0[e]} = m_mem[int'(m_addr[e][11:4])];
            wb_read(dma_a(e, 6), d);
            checks++;
            if (d !== m_rd0[e]) begin errors++; $display("FAIL rdata0 dma%0d: got %h expected %h", e, d, m_rd0[e]); end
            wb_read(dma_a(e, 7), d);
            checks++;
            if (d !== m_rd1[e]) begin errors++; $display("FAIL rdata1 dma%0d: got %h expected %h", e, d, m_rd1[e]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        for (int e = 0; e < 2; e++) begin
            m_addr[e] = 64'h240; m_wd0[e] = {$urandom, $urandom}; m_wd1[e] = {$urandom, $urandom};
            wb_write(dma_a(e, 3), m_addr[e], 8'hFF);
            wb_write(dma_a(e, 4), m_wd0[e], 8'hFF);
            wb_write(dma_a(e, 5), m_wd1[e], 8'hFF);
        end
        wb_write(dma_a(0, 1), 64'd1, 8'hFF);
        wb_write(dma_a(1, 1), 64'd1, 8'hFF);
        // DMA1 is still busy 5 edges after the DMA0 start (its own latency plus the one-cycle offset)
        for (int k = 0; k < LAT; k++) begin
            wb_read(dma_a(1, 0), d);
            checks++;
            if (d !== 64'd1) begin errors++; $display("FAIL b2b_dma1_busy cycle%0d: got %h expected 1", k + 2, d); end
            tick(1);
        end
        wb_read(dma_a(1, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL b2b_dma1_done: got %h expected 0", d); end
        wb_read(dma_a(0, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL b2b_dma0_done: got %h expected 0", d); end
        m_mem[36] = {m_wd1[1], m_wd0[1]};
        wb_write(dma_a(0, 2), 64'd1, 8'hFF);
        wait_idle(0);
        {m_rd1[0], m_rd0[0]} = m_mem[36];
        wb_read(dma_a(0, 6), d);
        checks++;
        if (d !== m_rd0[0]) begin errors++; $display("FAIL b2b_mem_lo: got %h expected %h", d, m_rd0[0]); end
        wb_read(dma_a(0, 7), d);
        checks++;
        if (d !== m_rd1[0]) begin errors++; $display("FAIL b2b_mem_hi: got %h expected %h", d, m_rd1[0]); end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] d;
        wb_write(dma_a(0, 1), 64'd2, 8'hFF);
        wb_read(dma_a(0, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL start_bit0_clear: got %h expected 0", d); end
        m_addr[0] = 64'h50; m_wd0[0] = {$urandom, $urandom}; m_wd1[0] = {$urandom, $urandom};
        wb_write(dma_a(0, 3), m_addr[0], 8'hFF);
        wb_write(dma_a(0, 4), m_wd0[0], 8'hFF);
        wb_write(dma_a(0, 5), m_wd1[0], 8'hFF);
        wb_write(dma_a(0, 1), 64'd1, 8'hFF);
        wb_write(dma_a(0, 2), 64'd1, 8'hFF);
        for (int k = 0; k < LAT - 1; k++) begin
            wb_read(dma_a(0, 0), d);
            checks++;
            if (d !== 64'd1) begin errors++; $display("FAIL swb_busy cycle%0d: got %h expected 1", k + 2, d); end
            tick(1);
        end
        wb_read(dma_a(0, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL swb_done: got %h expected 0", d); end
        wb_read(dma_a(0, 6), d);
        checks++;
        if (d !== m_rd0[0]) begin errors++; $display("FAIL swb_rdata_kept: got %h expected %h", d, m_rd0[0]); end
        m_mem[5] = {m_wd1[0], m_wd0[0]};
    endtask

    task automatic test_random_dma();
        logic [63:0] d, a, w;
        logic [7:0]  s, ix;
        int          e;
        for (int it = 0; it < 24; it++) begin
            e  = $urandom_range(0, 1);
            ix = 8'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            a[11:4] = ix;
            wb_write(dma_a(e, 3), a, 8'hFF);
            m_addr[e] = a;
            w = {$urandom, $urandom}; s = 8'($urandom);
            wb_write(dma_a(e, 4), w, s);
            m_wd0[e] = bmerge(m_wd0[e], w, s);
            w = {$urandom, $urandom}; s = 8'($urandom);
            wb_write(dma_a(e, 5), w, s);
            m_wd1[e] = bmerge(m_wd1[e], w, s);
            wb_read(dma_a(e, 4), d);
            checks++;
            if (d !== m_wd0[e]) begin errors++; $display("FAIL rnd_wdata0 it%0d: got %h expected %h", it, d, m_wd0[e]); end
            wb_read(dma_a(e, 5), d);
            checks++;
            if (d !== m_wd1[e]) begin errors++; $display("FAIL rnd_wdata1 it%0d: got %h expected %h", it, d, m_wd1[e]); end
            if (!m_mem.exists(int'(ix)) || $urandom_range(0, 1) == 0) begin
                wb_write(dma_a(e, 1), 64'd1, 8'hFF);
                wait_idle(e);
                m_mem[int'(ix)] = {m_wd1[e], m_wd0[e]};
            end else begin
                wb_write(dma_a(e, 2), 64'd1, 8'hFF);
                wait_idle(e);
                {m_rd1[e], m_rd0[e]} = m_mem[int'(ix)];
                wb_read(dma_a(e, 6), d);
                checks++;
                if (d !== m_rd0[e]) begin errors++; $display("FAIL rnd_rdata0 it%0d: got %h expected %h", it, d, m_rd0[e]); end
                wb_read(dma_a(e, 7), d);
                checks++;
                if (d !== m_rd1[e]) begin errors++; $display("FAIL rnd_rdata1 it%0d: got %h expected %h", it, d, m_rd1[e]); end
            end
        end
    endtask

    task automatic test_led();
        logic [63:0] d, w;
        logic [7:0]  s;
        for (int it = 0; it < 8; it++) begin
            w = {$urandom, $urandom};
            s = (it == 0) ? 8'hFE : 8'($urandom);
            wb_write(LED_A, w, s);
            if (s[0]) m_led = w[7:0];
            wb_read(LED_A, d);
            checks++;
            if (d !== {56'd0, m_led}) begin errors++; $display("FAIL led it%0d: got %h expected %h", it, d, {56'd0, m_led}); end
        end
    endtask

    task automatic test_timer();
        logic [63:0] d;
`ifdef UDMABUF_TB_MAIN_TIMER_EN
        wb_write(tim_a(1), 64'd3, 8'hFF);
        tim_edge(1'b0, 1'b0);
        t_cmp = 64'd3;
        wb_write(tim_a(0), 64'd1, 8'hFF);
        tim_edge(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wb_read(tim_a(3), d);
            checks++;
            if (d !== t_cnt) begin errors++; $display("FAIL tim_count step%0d: got %h expected %h", k, d, t_cnt); end
            tick(1);
            tim_edge(1'b0, 1'b0);
        end
        wb_write(tim_a(0), 64'd0, 8'hFF);
        tim_edge(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wb_read(tim_a(3), d);
            checks++;
            if (d !== t_cnt) begin errors++; $display("FAIL tim_hold step%0d: got %h expected %h", k, d, t_cnt); end
            tick(1);
            tim_edge(1'b0, 1'b0);
        end
        wb_write(tim_a(0), 64'd1, 8'hFF);
        tim_edge(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            tim_edge(1'b0, 1'b0);
            wb_read(tim_a(3), d);
            checks++;
            if (d !== t_cnt) begin errors++; $display("FAIL tim_resume step%0d: got %h expected %h", k, d, t_cnt); end
        end
        wb_read(tim_a(0), d);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL tim_control: got %h expected 1", d); end
`else
        wb_write(tim_a(1), 64'd3, 8'hFF);
        wb_write(tim_a(0), 64'd1, 8'hFF);
        tick(3);
        for (int r = 0; r < 4; r++) begin
            wb_read(tim_a(r), d);
            checks++;
            if (d !== 64'd0) begin errors++; $display("FAIL tim_absent reg%0d: got %h expected 0", r, d); end
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [63:0] d;
        logic [63:0] p0, p1;
        p0 = {$urandom, $urandom};
        p1 = {$urandom, $urandom};
        wb_write(dma_a(0, 3), 64'h300, 8'hFF);
        wb_write(dma_a(0, 4), p0, 8'hFF);
        wb_write(dma_a(0, 5), p1, 8'hFF);
        wb_write(dma_a(0, 1), 64'd1, 8'hFF);
        tick(1);
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        model_reset();
        m_mem.delete();
        tick(1);
        wb_read(dma_a(0, 0), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL abort_status: got %h expected 0", d); end
        wb_read(dma_a(0, 3), d);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL abort_addr: got %h expected 0", d); end
        tick(LAT + 1);
        wb_write(dma_a(0, 3), 64'h300, 8'hFF);
        wb_write(dma_a(0, 2), 64'd1, 8'hFF);
        wait_idle(0);
        wb_read(dma_a(0, 6), d);
        checks++;
        if (d === p0) begin errors++; $display("FAIL abort_mem_lo: got %h expected anything but %h", d, p0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_core_id();
        test_dma0_write();
        test_dma1_and_reads();
        test_back_to_back();
        test_start_while_busy();
        test_random_dma();
        test_led();
        test_timer();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
